// File: rtl/vga_timing_gen_if.sv
// Video timing bundle between the timing generator (master) and downstream
// draw/overlay stages (slave): pixel enable in, counters, flags and strobes out.
interface vga_timing_gen_if #(
    parameter int CW       = 11,
    parameter int FRAME_CW = 16
);
    logic                ce;
    logic [CW-1:0]       hcount;
    logic [CW-1:0]       vcount;
    logic                hblnk;
    logic                vblnk;
    logic                hsync;
    logic                vsync;
    logic                sol;
    logic                sof;
    logic [FRAME_CW-1:0] frame_cnt;

    modport master (
        input  ce,
        output hcount, vcount, hblnk, vblnk, hsync, vsync, sol, sof, frame_cnt
    );

    modport slave (
        output ce,
        input  hcount, vcount, hblnk, vblnk, hsync, vsync, sol, sof, frame_cnt
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with pixel enable, sync polarity and line/frame strobes.
// Optional completed-frame counter is built only when VGA_TIMING_FRAME_CNT_EN is defined.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 800,
    parameter int H_FP      = 40,
    parameter int H_SYNC    = 128,
    parameter int H_BP      = 88,
    parameter int V_ACTIVE  = 600,
    parameter int V_FP      = 1,
    parameter int V_SYNC    = 4,
    parameter int V_BP      = 23,
    parameter bit HSYNC_POL = 1'b1,
    parameter bit VSYNC_POL = 1'b1,
    parameter int CW        = 11,
    parameter int FRAME_CW  = 16
) (
    input logic              clk,
    input logic              rst_n,
    vga_timing_gen_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int H_SS    = H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int V_SS    = V_ACTIVE + V_FP;

    localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_C = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_C = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_SS_C  = CW'(H_SS);
    localparam logic [CW-1:0] H_SE_C  = CW'(H_SS + H_SYNC);
    localparam logic [CW-1:0] V_SS_C  = CW'(V_SS);
    localparam logic [CW-1:0] V_SE_C  = CW'(V_SS + V_SYNC);

    if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_porch
        $fatal(1, "vga_timing_gen: every porch and sync width must be at least 1");
    end
    if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_cw
        $fatal(1, "vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CW bits");
    end

    logic [CW-1:0] hcount_q, hcount_d;
    logic [CW-1:0] vcount_q, vcount_d;
    logic          hblnk_q, hblnk_d;
    logic          vblnk_q, vblnk_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          sol_q, sol_d;
    logic          sof_q, sof_d;
    logic          h_wrap;
    logic          v_wrap;

    // Flags are decoded from the next counter values so they register alongside them.
    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        sol_d    = 1'b0;
        sof_d    = 1'b0;
        h_wrap   = (hcount_q == H_LAST);
        v_wrap   = (vcount_q == V_LAST);
        if (vga.ce) begin
            if (h_wrap) begin
                hcount_d = '0;
                sol_d    = 1'b1;
                if (v_wrap) begin
                    vcount_d = '0;
                    sof_d    = 1'b1;
                end else begin
                    vcount_d = vcount_q + CW'(1);
                end
            end else begin
                hcount_d = hcount_q + CW'(1);
            end
        end
        hblnk_d = (hcount_d >= H_ACT_C);
        vblnk_d = (vcount_d >= V_ACT_C);
        hsync_d = ((hcount_d >= H_SS_C) && (hcount_d < H_SE_C)) ^ ~HSYNC_POL;
        vsync_d = ((vcount_d >= V_SS_C) && (vcount_d < V_SE_C)) ^ ~VSYNC_POL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_q <= '0;
            vcount_q <= '0;
            hblnk_q  <= 1'b0;
            vblnk_q  <= 1'b0;
            hsync_q  <= ~HSYNC_POL;
            vsync_q  <= ~VSYNC_POL;
            sol_q    <= 1'b0;
            sof_q    <= 1'b0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hblnk_q  <= hblnk_d;
            vblnk_q  <= vblnk_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            sol_q    <= sol_d;
            sof_q    <= sof_d;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [FRAME_CW-1:0] frame_cnt_q, frame_cnt_d;

    // Advances on the same edge that raises sof, so both appear together.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (sof_d) begin
            frame_cnt_d = frame_cnt_q + FRAME_CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign vga.frame_cnt = frame_cnt_q;
`else
    assign vga.frame_cnt = '0;
`endif

    assign vga.hcount = hcount_q;
    assign vga.vcount = vcount_q;
    assign vga.hblnk  = hblnk_q;
    assign vga.vblnk  = vblnk_q;
    assign vga.hsync  = hsync_q;
    assign vga.vsync  = vsync_q;
    assign vga.sol    = sol_q;
    assign vga.sof    = sof_q;
endmodule
